// File: rtl/sa2_scheduler.sv
// sa2_scheduler: round-robin two-requester job scheduler driving the 2x2 systolic array.
// Optional RUN-cycle timeout abort is enabled by defining SA2_SCHED_TIMEOUT_EN.
module sa2_scheduler #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req,
    output logic [1:0]   req_ready,
    input  logic [127:0] a0,
    input  logic [127:0] a1,
    input  logic [71:0]  b0,
    input  logic [71:0]  b1,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_id,
    output logic [31:0]  resp_c,
    output logic         resp_err,
    output logic         busy,
    output logic         sa_rst,
    output logic         sa_active,
    output logic [127:0] sa_a,
    output logic [71:0]  sa_b,
    input  logic         sa_done,
    input  logic [31:0]  sa_c
);
    typedef enum logic [1:0] {IDLE, CLR, RUN, RESP} state_t;

    if (TIMEOUT < 30 || (2 ** CNT_W) <= TIMEOUT) begin : g_bad_cfg
        $error("sa2_scheduler: TIMEOUT must be >= 30 and below 2**CNT_W");
    end

    state_t         state_q;
    logic           pri_q;
    logic           id_q;
    logic           valid_q;
    logic           active_q;
    logic [127:0]   a_q;
    logic [71:0]    b_q;
    logic [31:0]    c_q;
    logic           gnt_id;

    // pri_q names the requester that wins a tie
    assign gnt_id     = (req == 2'b11) ? pri_q : req[1];
    assign req_ready  = (rst_n && state_q == IDLE && |req) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
    assign busy       = state_q != IDLE;
    assign sa_rst     = !rst_n || state_q == CLR;
    assign sa_active  = active_q;
    assign sa_a       = a_q;
    assign sa_b       = b_q;
    assign resp_valid = valid_q;
    assign resp_id    = id_q;
    assign resp_c     = c_q;

`ifdef SA2_SCHED_TIMEOUT_EN
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;
    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pri_q    <= 1'b0;
            id_q     <= 1'b0;
            valid_q  <= 1'b0;
            active_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
`ifdef SA2_SCHED_TIMEOUT_EN
            err_q    <= 1'b0;
            cnt_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (|req) begin
                    state_q <= CLR;
                    pri_q   <= ~gnt_id;
                    id_q    <= gnt_id;
                    a_q     <= gnt_id ? a1 : a0;
                    b_q     <= gnt_id ? b1 : b0;
                end
                CLR: begin
                    state_q  <= RUN;
                    active_q <= 1'b1;
`ifdef SA2_SCHED_TIMEOUT_EN
                    cnt_q    <= CNT_W'(1);
`endif
                end
                RUN: if (sa_done) begin
                    state_q  <= RESP;
                    active_q <= 1'b0;
                    valid_q  <= 1'b1;
                    c_q      <= sa_c;
`ifdef SA2_SCHED_TIMEOUT_EN
                    err_q    <= 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    state_q  <= RESP;
                    active_q <= 1'b0;
                    valid_q  <= 1'b1;
                    c_q      <= '0;
                    err_q    <= 1'b1;
                end else begin
                    cnt_q    <= cnt_q + 1'b1;
`endif
                end
                RESP: if (resp_ready) begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
